// File: rtl/alu_seq_pkg.sv
// Shared constants for the multi-cycle slice sequencer.
// ALU_SEQ_ASR_EN: when defined, op 101 is arithmetic shift right.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_POP = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b101;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifdef ALU_SEQ_ASR_EN
  localparam logic ASR_EN = 1'b1;
`else
  localparam logic ASR_EN = 1'b0;
`endif

  function automatic logic op_ok(
    input logic [2:0] op
  );
    return (op == OP_ADD) ||
           (op == OP_SHR) ||
           (op == OP_POP) ||
           (op == OP_CMP) ||
           (ASR_EN && (op == OP_ASR));
  endfunction

endpackage

// File: rtl/alu_slice_sequencer_slice.sv
// One S-bit ALU slice: add, shift-right,
// popcount and unsigned compare, purely combinational.
module alu_slice
  import alu_seq_pkg::*;
#(
  parameter int S = 4
) (
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic [2:0]   op,
  input  logic         p_c,
  output logic [S-1:0] out,
  output logic         n_c,
  output logic [1:0]   cmp
);

  logic [S:0]   sum;
  logic [S-1:0] cnt;

  // per-slice arithmetic selected by op
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, p_c};
    cnt = '0;
    for (int i = 0; i < S; i++) begin
      cnt = cnt + {{(S-1){1'b0}}, a[i]};
    end
    out = '0;
    n_c = 1'b0;
    cmp = CMP_EQ;
    unique case (1'b1)
      (op == OP_ADD): begin
        out = sum[S-1:0];
        n_c = sum[S];
      end
      (op == OP_SHR): begin
        out = {p_c, a[S-1:1]};
        n_c = a[0];
      end
      (op == OP_POP): begin
        out = cnt;
      end
      (op == OP_CMP): begin
        if (a > b)
          cmp = CMP_GT;
        else if (a < b)
          cmp = CMP_LT;
      end
      default: begin
        out = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_slice_sequencer.sv
// Runs a W-bit op through one S-bit slice, one slice per cycle.
// ALU_SEQ_ASR_EN enables op 101 (arithmetic shift right).
module alu_slice_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W = 16,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_carry,
  output logic [1:0]   out_cmp,
  output logic         out_err
);

  localparam int N  = W / S;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic [2:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          cin_q;
  logic          cy_q;
  logic [W-1:0]  res_q;
  logic          carry_q;
  logic [1:0]    cmp_q;
  logic          err_q;

  logic          run;
  logic          is_add;
  logic          is_shift;
  logic          is_pop;
  logic          is_cmp;
  logic          msb_first;
  logic [KW-1:0] idx;
  int            base;
  logic          pc0;

  logic [S-1:0]  sl_a;
  logic [S-1:0]  sl_b;
  logic [2:0]    sl_op;
  logic          sl_pc;
  logic [S-1:0]  sl_out;
  logic          sl_nc;
  logic [1:0]    sl_cmp;

  assign run      = (state == ST_RUN);
  assign is_add   = (op_q == OP_ADD);
  assign is_shift = (op_q == OP_SHR) ||
                    (ASR_EN && (op_q == OP_ASR));
  assign is_pop   = (op_q == OP_POP);
  assign is_cmp   = (op_q == OP_CMP);

  assign msb_first = is_shift || is_cmp;

  // slice selection and slice input muxing
  always_comb begin
    idx   = msb_first ? (K_LAST - k) : k;
    base  = int'(idx) * S;
    pc0   = 1'b0;
    sl_a  = '0;
    sl_b  = '0;
    sl_op = '0;
    sl_pc = 1'b0;
    if (is_add)
      pc0 = cin_q;
    else if (ASR_EN && (op_q == OP_ASR))
      pc0 = a_q[W-1];
    if (run) begin
      sl_a  = a_q[base +: S];
      sl_b  = b_q[base +: S];
      sl_op = is_shift ? OP_SHR : op_q;
      sl_pc = (k == '0) ? pc0 : cy_q;
    end
  end

  alu_slice #(
    .S (S)
  ) u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .op  (sl_op),
    .p_c (sl_pc),
    .out (sl_out),
    .n_c (sl_nc),
    .cmp (sl_cmp)
  );

  // request accept, slice stepping, result merge and handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      k       <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cmp_q   <= CMP_EQ;
      err_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (in_valid) begin
            op_q    <= in_op;
            a_q     <= in_a;
            b_q     <= in_b;
            cin_q   <= in_cin;
            k       <= '0;
            cy_q    <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cmp_q   <= CMP_EQ;
            if (op_ok(in_op)) begin
              err_q <= 1'b0;
              state <= ST_RUN;
            end else begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        (state == ST_RUN): begin
          cy_q <= sl_nc;
          k    <= k + 1'b1;
          if (is_add || is_shift)
            res_q[base +: S] <= sl_out;
          else if (is_pop)
            res_q <= res_q +
                     {{(W-S){1'b0}}, sl_out};
          else if (is_cmp && (cmp_q == CMP_EQ))
            cmp_q <= sl_cmp;
          if (k == K_LAST) begin
            carry_q <= (is_add || is_shift) ?
                       sl_nc : 1'b0;
            state   <= ST_DONE;
          end
        end
        (state == ST_DONE): begin
          if (out_ready)
            state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_res   = res_q;
  assign out_carry = carry_q;
  assign out_cmp   = cmp_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Randomized bench for alu_slice_sequencer against
// a word-level arithmetic reference model.
module tb_alu_slice_sequencer;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_carry;
  logic [1:0]   out_cmp;
  logic         out_err;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_slice_sequencer #(
    .W (16),
    .S (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_carry (out_carry),
    .out_cmp   (out_cmp),
    .out_err   (out_err)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic model(
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] r,
    output logic         c,
    output logic [1:0]   cm,
    output logic         e
  );
    logic [W:0] s;
    r  = '0;
    c  = 1'b0;
    cm = 2'b00;
    e  = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b} + 17'(cin);
        r = s[W-1:0];
        c = s[W];
      end
      3'd1: begin
        r = a >> 1;
        c = a[0];
      end
      3'd2: r = 16'($countones(a));
      3'd3: begin
        if (a > b)
          cm = 2'b01;
        else if (a < b)
          cm = 2'b10;
      end
`ifdef ALU_SEQ_ASR_EN
      3'd5: begin
        r = 16'($signed(a) >>> 1);
        c = a[0];
      end
`endif
      default: e = 1'b1;
    endcase
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_op(
    input logic [2:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin,
    input int           hold
  );
    logic [W-1:0] er;
    logic         ec;
    logic [1:0]   ecm;
    logic         ee;
    int           lat;
    int           elat;
    model(op, a, b, cin, er, ec, ecm, ee);
    elat = ee ? 0 : N;
    check("rdy_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    if (!ee)
      check("rdy_busy", 32'(in_ready), 32'd0);
    while (!out_valid && lat < 20) begin
      in_a   = 16'($urandom);
      in_b   = 16'($urandom);
      in_op  = 3'($urandom);
      in_cin = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    if (!out_valid) begin
      do_reset();
      return;
    end
    check("res", 32'(out_res), 32'(er));
    check("carry", 32'(out_carry), 32'(ec));
    check("cmp", 32'(out_cmp), 32'(ecm));
    check("err", 32'(out_err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      in_a = 16'($urandom);
      @(posedge clk);
      #1;
      check("hold",
            32'({out_valid, in_ready, out_res,
                 out_carry, out_cmp, out_err}),
            32'({1'b1, 1'b0, er, ec, ecm, ee}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("handshake",
          32'({out_valid, in_ready}), 32'd1);
  endtask

  task automatic reset_mid_run();
    int seen;
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    in_cin   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_outs",
          32'({out_valid, out_res, out_carry,
               out_cmp, out_err}), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid)
        seen++;
    end
    check("rst_noval", 32'(seen), 32'd0);
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", 32'(in_ready), 32'd1);
    check("reset_outs",
          32'({out_valid, out_res, out_carry,
               out_cmp, out_err}), 32'd0);
    rst_n = 1'b1;

    do_op(3'd0, 16'h00FF, 16'h0001, 1'b0, 0);
    do_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(3'd0, 16'hFFFF, 16'h0000, 1'b1, 0);
    do_op(3'd1, 16'hB00B, 16'h0000, 1'b0, 0);
    do_op(3'd2, 16'hF0F1, 16'h0000, 1'b0, 0);
    do_op(3'd2, 16'hFFFF, 16'h0000, 1'b0, 0);
    do_op(3'd3, 16'h1234, 16'h1235, 1'b0, 0);
    do_op(3'd3, 16'h8000, 16'h7FFF, 1'b0, 0);
    do_op(3'd3, 16'hA5A5, 16'hA5A5, 1'b0, 0);
    do_op(3'd0, 16'h1357, 16'h2468, 1'b1, 5);
    reset_mid_run();
    do_op(3'd0, 16'h0003, 16'h0005, 1'b0, 0);
    do_op(3'd4, 16'h1234, 16'h0000, 1'b0, 0);
    do_op(3'd5, 16'h8004, 16'h0000, 1'b0, 0);
    do_op(3'd7, 16'hFFFF, 16'hFFFF, 1'b1, 1);

    for (int t = 0; t < 80; t++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ?
            ra : 16'($urandom);
      do_op(rop, ra, rb, 1'($urandom),
            int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
Drives a single S-bit alu_slice over multiple cycles to execute a W-bit operation, one slice per cycle. It is the issuing end of the slice interface (a, b, op, p_c out; out, n_c, cmp in). It sequences slice order and carries n_c into the next slice's p_c through a register. It merges partial results and returns them over a valid/ready handshake. It sits between the CPU execute stage and the slice datapath.

Parameters:
W, 16, full operand width; must be a multiple of S.
S, 4, slice width; must be at least 2.
N, W/S, number of slice steps (derived localparam); must be at least 2.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_op  in  3  000 add, 001 shift right, 010 popcount, 011 compare, 101 ASR (optional)
in_a  in  W  operand A
in_b  in  W  operand B
in_cin  in  1  add carry-in
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  consumer ready
out_res  out  W  result
out_carry  out  1  add carry-out, or the bit shifted out
out_cmp  out  2  01 A>B, 10 A<B, 00 equal (unsigned)
out_err  out  1  unsupported op

Behaviour:
- Reset: one clock with rst_n=0.
  - State goes to IDLE.
  - All outputs go to 0, except in_ready, which goes to 1.
  - Operand, accumulator and carry registers go to 0.
- Reset during RUN or DONE aborts the operation. No out_valid is produced.
- States and transitions:
  - IDLE: in_ready=1. On accept, latch op, a, b and cin, set step k=0, go to RUN.
  - RUN: in_ready=0. One slice step per cycle; the slice output is combinational and sampled at the cycle's edge. After step N-1, go to DONE.
  - DONE: out_valid=1 and all out_* stable. When out_ready=1, go to IDLE.
- Latency: out_valid rises exactly N cycles after the accept edge. in_ready returns one cycle after the out handshake, so there is a one-cycle bubble with no overlap.
- Outside RUN, internal slice inputs are driven to 0.
- Add (000): LSB slice first.
  - p_c for step 0 is cin; p_c for later steps is the registered n_c of the previous step.
  - out_carry is the n_c of step N-1.
- Shift right (001): MSB slice first.
  - p_c for step 0 is 0.
  - Each slice's n_c becomes the next lower slice's p_c.
  - out_carry is bit 0 of A.
- Popcount (010): slice order LSB first, p_c=0.
  - Slice out is a count from 0 to S; it is added into a W-bit accumulator.
  - out_res is the zero-extended total, from 0 to W.
- Compare (011): MSB slice first, cmp result is sticky.
  - The first non-00 slice cmp is latched and later slices are ignored.
  - If every slice returns 00, out_cmp=00.
  - out_res=0 and out_carry=0.
- Unsupported op: goes IDLE→DONE in one cycle with no slice activity. out_err=1, out_res=0, out_carry=0, out_cmp=00.
- out_cmp=00 for all non-compare ops. out_err=0 for all supported ops.
- Input operands are sampled only at accept. Changes to in_* during RUN or DONE are ignored.

Optional Feature:
- ALU_SEQ_ASR_EN defined:
  - op 101 is arithmetic shift right.
  - It behaves like 001, except step-0 p_c = A[W-1].
- ALU_SEQ_ASR_EN undefined: op 101 is unsupported (out_err=1).

Decomposition:
- Package alu_seq_pkg holds:
  - op code constants (OP_ADD, OP_SHR, OP_POP, OP_CMP, OP_ASR);
  - cmp code constants (CMP_EQ, CMP_GT, CMP_LT);
  - the state encoding (IDLE, RUN, DONE).
- The one sub-module is alu_slice, instantiated once with parameter S.
- Slice-index and mux logic stays inline.

Test Plan:
- Add 0x00FF+0x0001, cin=0 -> res=0x0100, carry=0. Add 0xFFFF+0x0001 -> res=0x0000, carry=1. Add 0xFFFF+0x0000, cin=1 -> res=0x0000, carry=1. In all three, out_valid rises 4 cycles after accept.
- Shift 0xB00B, op 001 -> res=0x5805, carry=1. Popcount 0xF0F1 -> res=0x0009. Popcount 0xFFFF -> res=0x0010.
- Compare 0x1234 vs 0x1235 -> cmp=10. Compare 0x8000 vs 0x7FFF -> cmp=01 (decided in the MSB slice). Compare 0xA5A5 vs 0xA5A5 -> cmp=00.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_* stable, in_ready=0. Then raise out_ready -> IDLE, and in_ready=1 on the next cycle.
- Reset: assert rst_n=0 at RUN step 2 -> no out_valid, all outputs 0, in_ready=1. A following add 0x0003+0x0005 -> res=0x0008.
- op 100 -> out_err=1 one cycle after accept. With ALU_SEQ_ASR_EN, 0x8004 op 101 -> res=0xC002, carry=0; without it -> out_err=1.
